// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter that locks a 4:1 data mux onto one requester for a burst
// of up to MAX_BURST beats, then re-arbitrates from the requester after the last winner.
module rr_mux_arbiter_4 #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    grant_q, grant_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    win_s;
    logic          win_found_s;
    logic [1:0]    idx_s;

    // Rotating priority scan starting at ptr_q; first valid requester wins.
    always_comb begin
        win_s       = ptr_q;
        win_found_s = 1'b0;
        idx_s       = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_q + 2'(k);
            if (!win_found_s && in_valid[idx_s]) begin
                win_found_s = 1'b1;
                win_s       = idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic; a release clears the grant and moves ptr past the releaser.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d = BUSY;
                    sel_d   = win_s;
                    grant_d = 4'b0001 << win_s;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Counter advances on beats only, so a stalled consumer holds the grant.
                if (!in_valid[sel_q] || (out_ready && cnt_q == LAST_BEAT)) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake and data paths stay combinational so beats move with no added latency.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 4'b0000;
        if (state_q == BUSY) begin
            out_valid = in_valid[sel_q];
            in_ready  = out_ready ? (4'b0001 << sel_q) : 4'b0000;
        end else begin
            out_valid = 1'b0;
            in_ready  = 4'b0000;
        end
        case (sel_q)
            2'd0:    out_data = in_data0;
            2'd1:    out_data = in_data1;
            2'd2:    out_data = in_data2;
            2'd3:    out_data = in_data3;
            default: out_data = in_data0;
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule
